// File: rtl/debounce_pkg.sv
// Shared constants for the button debouncer: FSM state encoding and
// the default / minimum stability window.
package debounce_pkg;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_CONFIRM = 1'b1;

    localparam int DEFAULT_STABLE_CYCLES = 16;
    localparam int MIN_STABLE_CYCLES     = 2;

endpackage

// File: rtl/button_debouncer_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; reusable by any
// block that samples an input from outside the CLK domain.
module sync_2ff (
    input  logic CLK,
    input  logic RESET,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/button_debouncer.sv
// Debounces a raw push-button level into a clean registered BTN_OUT.
// Define DEBOUNCE_PULSE_EN to add the PRESS_PULSE / RELEASE_PULSE outputs.
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic CLK,
    input  logic RESET,
    input  logic BTN_IN,
    output logic BTN_OUT
`ifdef DEBOUNCE_PULSE_EN
    ,
    output logic PRESS_PULSE,
    output logic RELEASE_PULSE
`endif
);

    generate
        if (STABLE_CYCLES < MIN_STABLE_CYCLES) begin : g_param_check
            $error("button_debouncer: STABLE_CYCLES must be at least 2");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s2;
    logic             diff;
    logic             commit;
    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             btn_q, btn_d;

    sync_2ff u_sync (
        .CLK   (CLK),
        .RESET (RESET),
        .d_i   (BTN_IN),
        .q_o   (s2)
    );

    assign diff = (s2 != btn_q);

    // A bounce back to the current level abandons the count; the counter
    // therefore tops out at CNT_LAST and can never wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        btn_d   = btn_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (diff) begin
                    state_d = ST_CONFIRM;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_CONFIRM: begin
                if (!diff) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    btn_d   = s2;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            btn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            btn_q   <= btn_d;
        end
    end

    assign BTN_OUT = btn_q;

`ifdef DEBOUNCE_PULSE_EN
    logic press_q;
    logic release_q;

    // Registered alongside btn_q so each pulse lines up with the level change.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            press_q   <= commit & s2;
            release_q <= commit & ~s2;
        end
    end

    assign PRESS_PULSE   = press_q;
    assign RELEASE_PULSE = release_q;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer with STABLE_CYCLES = 4; pulse
// outputs are checked when DEBOUNCE_PULSE_EN is defined.
module tb_button_debouncer;

    localparam int S = 4;

    logic CLK = 1'b0;
    logic RESET;
    logic BTN_IN;
    logic BTN_OUT;
    logic press;
    logic rel;

`ifdef DEBOUNCE_PULSE_EN
    button_debouncer #(.STABLE_CYCLES(S)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .BTN_IN        (BTN_IN),
        .BTN_OUT       (BTN_OUT),
        .PRESS_PULSE   (press),
        .RELEASE_PULSE (rel)
    );
`else
    button_debouncer #(.STABLE_CYCLES(S)) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .BTN_IN  (BTN_IN),
        .BTN_OUT (BTN_OUT)
    );
    assign press = 1'b0;
    assign rel   = 1'b0;
`endif

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       out;
        logic       pr;
        logic       rl;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   press_cnt = 0;
    int   rel_cnt   = 0;

    // Reference: a run-length of cycles where the synchronised input
    // disagrees with the output; reaching S flips the output.
    logic m_s1, m_s2, m_out;
    int   m_run;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_s1  = 1'b0;
        m_s2  = 1'b0;
        m_out = 1'b0;
        m_run = 0;
        sb.delete();
    endtask

    task automatic tick(input logic b);
        exp_t e;
        logic diff;
        BTN_IN = b;
        diff   = (m_s2 != m_out);
        e      = '0;
        if (diff) m_run++;
        else      m_run = 0;
        if (m_run == S) begin
            m_out = ~m_out;
            e.pr  = m_out;
            e.rl  = ~m_out;
            m_run = 0;
        end
        m_s2  = m_s1;
        m_s1  = b;
        e.out = m_out;
        e.cnt = 8'(m_run);
        sb.push_back(e);
        @(posedge CLK);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'(0), 32'(1));
        end else begin
            e = sb.pop_front();
            check("sb_out", 32'(BTN_OUT), 32'(e.out));
            check("sb_cnt", 32'(dut.cnt_q), 32'(e.cnt));
`ifdef DEBOUNCE_PULSE_EN
            check("sb_press", 32'(press), 32'(e.pr));
            check("sb_release", 32'(rel), 32'(e.rl));
`endif
        end
        if (press) press_cnt++;
        if (rel)   rel_cnt++;
    endtask

    initial begin
        RESET  = 1'b1;
        BTN_IN = 1'b1;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        check("rst_out", 32'(BTN_OUT), 32'(0));
        check("rst_cnt", 32'(dut.cnt_q), 32'(0));
        check("rst_state", 32'(dut.state_q), 32'(0));
        check("rst_press", 32'(press), 32'(0));
        check("rst_release", 32'(rel), 32'(0));

        // Button held through reset release
        RESET = 1'b0;
        press_cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            tick(1'b1);
            check("rst_rise", 32'(BTN_OUT), 32'(i >= 6));
`ifdef DEBOUNCE_PULSE_EN
            check("rst_press_edge", 32'(press), 32'(i == 6));
`endif
        end
`ifdef DEBOUNCE_PULSE_EN
        check("rst_press_count", 32'(press_cnt), 32'(1));
`endif

        // Release
        press_cnt = 0;
        rel_cnt   = 0;
        for (int i = 1; i <= 8; i++) begin
            tick(1'b0);
            check("rel_fall", 32'(BTN_OUT), 32'(i < 6));
        end
`ifdef DEBOUNCE_PULSE_EN
        check("rel_pulse_count", 32'(rel_cnt), 32'(1));
        check("rel_press_count", 32'(press_cnt), 32'(0));
`endif

        // Clean press
        press_cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            tick(1'b1);
            check("press_rise", 32'(BTN_OUT), 32'(i >= 6));
        end
`ifdef DEBOUNCE_PULSE_EN
        check("press_count", 32'(press_cnt), 32'(1));
`endif

        repeat (8) tick(1'b0);
        check("pre_bounce_out", 32'(BTN_OUT), 32'(0));

        // Bounce 1,1,0,0,1,1,0,0 then settle high
        press_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick(((i / 2) % 2) == 0);
            check("bounce_hold", 32'(BTN_OUT), 32'(0));
        end
        for (int k = 1; k <= 10; k++) begin
            tick(1'b1);
            check("bounce_settle", 32'(BTN_OUT), 32'(k >= 6));
        end
`ifdef DEBOUNCE_PULSE_EN
        check("bounce_press_count", 32'(press_cnt), 32'(1));
`endif

        repeat (8) tick(1'b0);

        // Short glitch: high for 3 cycles
        press_cnt = 0;
        repeat (3) tick(1'b1);
        for (int i = 0; i < 8; i++) begin
            tick(1'b0);
            check("glitch_out", 32'(BTN_OUT), 32'(0));
        end
        check("glitch_cnt", 32'(dut.cnt_q), 32'(0));
        check("glitch_press_count", 32'(press_cnt), 32'(0));

        // Async reset while counting a release
        repeat (8) tick(1'b1);
        check("amid_pre_out", 32'(BTN_OUT), 32'(1));
        repeat (4) tick(1'b0);
        check("amid_pre_cnt", 32'(dut.cnt_q), 32'(2));
        #2;
        RESET = 1'b1;
        model_reset();
        #1;
        check("amid_cnt", 32'(dut.cnt_q), 32'(0));
        check("amid_state", 32'(dut.state_q), 32'(0));
        check("amid_out", 32'(BTN_OUT), 32'(0));
        check("amid_press", 32'(press), 32'(0));
        check("amid_release", 32'(rel), 32'(0));
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick(1'b0);
            check("post_rst_out", 32'(BTN_OUT), 32'(0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
